// File: rtl/bitwise_slice_engine.sv
// Multi-cycle bitwise logic engine: evaluates AND/OR/XOR/NAND of two latched
// operands SLICE bits per cycle, then pulses done with the result and a zero flag.
module bitwise_slice_engine #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_lat_r;
    logic [WIDTH-1:0] b_lat_r;
    logic [1:0]       op_lat_r;
    logic [WIDTH-1:0] y_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;

    logic             accept_s;
    logic             last_s;
    logic [SLICE-1:0] slice_res_s;
    logic [WIDTH-1:0] y_upd_s;
    int               base_s;

    // One gate slice: the same 4-bit logic cells the ALU already owns.
    function automatic logic [SLICE-1:0] slice_op(
        input logic [1:0]       sel,
        input logic [SLICE-1:0] sa,
        input logic [SLICE-1:0] sb
    );
        logic [SLICE-1:0] r;
        case (sel)
            OP_AND:  r = sa & sb;
            OP_OR:   r = sa | sb;
            OP_XOR:  r = sa ^ sb;
            OP_NAND: r = ~(sa & sb);
            default: r = {SLICE{1'b0}};
        endcase
        return r;
    endfunction

    // Evaluate the current slice and form the result with that slice merged in.
    always_comb begin
        base_s      = int'(cnt_r) * SLICE;
        slice_res_s = slice_op(op_lat_r, a_lat_r[base_s +: SLICE], b_lat_r[base_s +: SLICE]);
        y_upd_s     = y_r;
        y_upd_s[base_s +: SLICE] = slice_res_s;
        last_s      = (cnt_r == CW'(NSLICE - 1));
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Control FSM, operand latches and result registers; reset drops any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            a_lat_r  <= {WIDTH{1'b0}};
            b_lat_r  <= {WIDTH{1'b0}};
            op_lat_r <= 2'b00;
            y_r      <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (accept_s) begin
            state_r  <= ST_RUN;
            cnt_r    <= {CW{1'b0}};
            a_lat_r  <= a;
            b_lat_r  <= b;
            op_lat_r <= op;
            y_r      <= {WIDTH{1'b0}};
            zero_r   <= 1'b0;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                ST_RUN: begin
                    y_r <= y_upd_s;
                    if (last_s) begin
                        state_r <= ST_DONE;
                        cnt_r   <= {CW{1'b0}};
                        zero_r  <= (y_upd_s == {WIDTH{1'b0}});
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign y    = y_r;
    assign zero = zero_r;

endmodule
